// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared types, defaults and width helper
// for the conv output bank scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_BANKS  = 10;
  localparam int DEF_BANK_DEPTH = 4096;

  // Width able to index n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bank_ptr_counter.sv
// bank_ptr_counter: word counter plus bank select, both
// wrapping at their configured limits.
module bank_ptr_counter
  import conv_sched_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int SEL_WIDTH  = width_of(NUM_BANKS),
  parameter int CNT_WIDTH  = width_of(BANK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 last_word,
  output logic                 last_bank
);

  assign last_word = (cnt == CNT_WIDTH'(BANK_DEPTH - 1));
  assign last_bank = (sel == SEL_WIDTH'(NUM_BANKS - 1));

  // Advance word count; wrap into the next bank at depth end.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
      sel <= '0;
    end else if (inc) begin
      if (last_word) begin
        cnt <= '0;
        sel <= last_bank ? '0 : sel + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_out_bank_sched.sv
// conv_out_bank_sched: fills NUM_BANKS FIFO banks in order, then
// drains them in order. Option: CONV_OUT_BANK_SCHED_FLAG_CHECK_EN.
module conv_out_bank_sched
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int SEL_WIDTH  = width_of(NUM_BANKS),
  parameter int CNT_WIDTH  = width_of(BANK_DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [DATA_WIDTH-1:0]           pxl_in,
  output logic [NUM_BANKS-1:0]            bank_wr_en,
  output logic [DATA_WIDTH-1:0]           bank_din,
  output logic [NUM_BANKS-1:0]            bank_rd_en,
  input  logic [NUM_BANKS-1:0]            bank_full,
  input  logic [NUM_BANKS-1:0]            bank_empty,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_dout,
  output logic [DATA_WIDTH-1:0]           pxl_out,
  output logic                            valid_out,
  output logic                            busy,
  output logic                            overflow,
  output logic                            flag_err
);

  sched_state_t state;

  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [SEL_WIDTH-1:0] wr_sel;
  logic                 wr_last_word;
  logic                 wr_last_bank;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [SEL_WIDTH-1:0] rd_sel;
  logic                 rd_last_word;
  logic                 rd_last_bank;

  logic do_wr;
  logic do_rd;
  logic wr_done;
  logic rd_done;

  logic                  rd_v_a;
  logic                  rd_v_b;
  logic [SEL_WIDTH-1:0]  sel_a;
  logic [SEL_WIDTH-1:0]  sel_b;
  logic [DATA_WIDTH-1:0] dout_sel;

  function automatic logic [NUM_BANKS-1:0] onehot(
    input logic [SEL_WIDTH-1:0] s
  );
    logic [NUM_BANKS-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Write/read qualification; empty gating holds the read counter.
  always_comb begin
    do_wr   = valid_in && (state != DRAIN);
    do_rd   = (state == DRAIN) && !bank_empty[rd_sel];
    wr_done = do_wr && wr_last_word && wr_last_bank;
    rd_done = do_rd && rd_last_word && rd_last_bank;
  end

  bank_ptr_counter #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH),
    .SEL_WIDTH (SEL_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wr (
    .clk      (clk),
    .reset    (reset),
    .inc      (do_wr),
    .clr      (wr_done),
    .cnt      (wr_cnt),
    .sel      (wr_sel),
    .last_word(wr_last_word),
    .last_bank(wr_last_bank)
  );

  bank_ptr_counter #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH),
    .SEL_WIDTH (SEL_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd (
    .clk      (clk),
    .reset    (reset),
    .inc      (do_rd),
    .clr      (wr_done),
    .cnt      (rd_cnt),
    .sel      (rd_sel),
    .last_word(rd_last_word),
    .last_bank(rd_last_bank)
  );

  // FSM with registered enables; rd_en is registered too so the
  // first read never lands in the same cycle as the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bank_wr_en <= '0;
      bank_din   <= '0;
      bank_rd_en <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bank_wr_en <= do_wr ? onehot(wr_sel) : '0;
      bank_rd_en <= do_rd ? onehot(rd_sel) : '0;
      if (do_wr) begin
        bank_din <= pxl_in;
      end
      case (state)
        IDLE: begin
          busy <= valid_in;
          if (valid_in) begin
            state <= wr_done ? DRAIN : FILL;
          end
        end
        FILL: begin
          busy <= 1'b1;
          if (wr_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          busy <= 1'b1;
          if (valid_in) begin
            overflow <= 1'b1;
          end
          if (rd_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bank word picked by the twice-delayed select.
  always_comb begin
    dout_sel = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (sel_b == SEL_WIDTH'(k)) begin
        dout_sel = bank_dout[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Two-stage output pipe; runs on after the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_a    <= 1'b0;
      rd_v_b    <= 1'b0;
      sel_a     <= '0;
      sel_b     <= '0;
      valid_out <= 1'b0;
      pxl_out   <= '0;
    end else begin
      rd_v_a    <= do_rd;
      sel_a     <= rd_sel;
      rd_v_b    <= rd_v_a;
      sel_b     <= sel_a;
      valid_out <= rd_v_b;
      if (rd_v_b) begin
        pxl_out <= dout_sel;
      end
    end
  end

`ifdef CONV_OUT_BANK_SCHED_FLAG_CHECK_EN
  logic unused_cnt;
  assign unused_cnt = ^wr_cnt;

  // Sticky error when bank flags disagree with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_err <= 1'b0;
    end else if ((|(bank_wr_en & bank_full)) ||
                 ((state == DRAIN) && bank_empty[rd_sel] &&
                  (rd_cnt != '0))) begin
      flag_err <= 1'b1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{wr_cnt, rd_cnt, bank_full};
  assign flag_err   = 1'b0;
`endif

endmodule

// File: tb/tb_conv_out_bank_sched.sv
// tb_conv_out_bank_sched: directed bench, 3 banks x 4 words,
// behavioural standard-mode FIFO banks.
module tb_conv_out_bank_sched;
  import conv_sched_pkg::*;

  localparam int DW = 32;
  localparam int NB = 3;
  localparam int BD = 4;

`ifdef CONV_OUT_BANK_SCHED_FLAG_CHECK_EN
  localparam logic FLAG_EXP = 1'b1;
`else
  localparam logic FLAG_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [DW-1:0]    pxl_in;
  logic [NB-1:0]    bank_wr_en;
  logic [DW-1:0]    bank_din;
  logic [NB-1:0]    bank_rd_en;
  logic [NB-1:0]    bank_full;
  logic [NB-1:0]    bank_empty;
  logic [NB*DW-1:0] bank_dout;
  logic [DW-1:0]    pxl_out;
  logic             valid_out;
  logic             busy;
  logic             overflow;
  logic             flag_err;

  logic  force_e1;
  int    checks;
  int    errors;

  logic [DW-1:0] mem [NB][BD];
  int            fcnt [NB];
  int            wp [NB];
  int            rp [NB];

  always #5 clk = ~clk;

  conv_out_bank_sched #(
    .DATA_WIDTH(DW),
    .NUM_BANKS (NB),
    .BANK_DEPTH(BD),
    .SEL_WIDTH (2),
    .CNT_WIDTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .pxl_in    (pxl_in),
    .bank_wr_en(bank_wr_en),
    .bank_din  (bank_din),
    .bank_rd_en(bank_rd_en),
    .bank_full (bank_full),
    .bank_empty(bank_empty),
    .bank_dout (bank_dout),
    .pxl_out   (pxl_out),
    .valid_out (valid_out),
    .busy      (busy),
    .overflow  (overflow),
    .flag_err  (flag_err)
  );

  // FIFO bank models: dout updates the cycle after rd_en.
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (reset) begin
        fcnt[k] <= 0;
        wp[k]   <= 0;
        rp[k]   <= 0;
        bank_dout[k*DW +: DW] <= '0;
      end else begin
        automatic bit w = bank_wr_en[k] && (fcnt[k] < BD);
        automatic bit r = bank_rd_en[k] && (fcnt[k] > 0);
        if (w) begin
          mem[k][wp[k]] <= bank_din;
          wp[k] <= (wp[k] + 1) % BD;
        end
        if (r) begin
          bank_dout[k*DW +: DW] <= mem[k][rp[k]];
          rp[k] <= (rp[k] + 1) % BD;
        end
        fcnt[k] <= fcnt[k] + int'(w) - int'(r);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      bank_full[k]  = (fcnt[k] == BD);
      bank_empty[k] = (fcnt[k] == 0) || ((k == 1) && force_e1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_en"}, 32'(bank_wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(bank_rd_en), 32'd0);
    chk({tag, "_din"}, bank_din, 32'd0);
    chk({tag, "_pxl"}, pxl_out, 32'd0);
    chk({tag, "_vout"}, 32'(valid_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_flag"}, 32'(flag_err), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  // 12 back-to-back words base..base+11; optional mapping checks.
  task automatic fill(input int base, input bit check);
    for (int i = 0; i < 12; i++) begin
      valid_in = 1'b1;
      pxl_in   = DW'(base + i);
      tick();
      if (check) begin
        chk("fill_wr_en", 32'(bank_wr_en), 32'(1 << (i / 4)));
        chk("fill_din", bank_din, 32'(base + i));
      end
    end
    valid_in = 1'b0;
    chk("fill_state", 32'(dut.state), 32'(DRAIN));
  endtask

  // Observe drain from the current cycle; lim stops after lim outputs.
  task automatic drain(input int base, input int lim, input bit timing,
                       input bit stall);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out) begin
        chk("drain_pxl", pxl_out, 32'(base + n));
        n++;
      end
      if (timing) begin
        if (i == 0) chk("no_overlap_rd", 32'(bank_rd_en), 32'd0);
        if (i == 1) chk("first_rd_en", 32'(bank_rd_en), 32'd1);
        if (i == 2) chk("vout_early", 32'(valid_out), 32'd0);
        if (i == 3) chk("first_vout", 32'(valid_out), 32'd1);
        if (i == 12) chk("busy_last_rd", 32'(busy), 32'd1);
        if (i == 13) chk("busy_fall", 32'(busy), 32'd0);
        if (i == 13) chk("idle_state", 32'(dut.state), 32'(IDLE));
      end
      if (stall) begin
        if (i == 6) chk("stall_rd_en", 32'(bank_rd_en), 32'd0);
        if (i == 7) chk("flag_err", 32'(flag_err), 32'(FLAG_EXP));
      end
      if (n == lim) break;
      force_e1 = stall && (i >= 5) && (i <= 7);
      tick();
    end
    force_e1 = 1'b0;
    chk("drain_count", 32'(n), 32'(lim));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    force_e1 = 1'b0;
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outs("reset");

    // Consecutive fill then in-order drain with timing.
    fill(1, 1'b1);
    chk("fill_busy", 32'(busy), 32'd1);
    drain(1, 12, 1'b1, 1'b0);
    tick();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_vout", 32'(valid_out), 32'd0);

    // Gapped fill: words on even cycles only.
    for (int c = 0; c < 24; c++) begin
      valid_in = (c % 2 == 0);
      pxl_in   = DW'(101 + c / 2);
      tick();
      if (c % 2 == 0) begin
        chk("gap_wr_en", 32'(bank_wr_en), 32'(1 << ((c / 2) / 4)));
        chk("gap_din", bank_din, 32'(101 + c / 2));
      end else begin
        chk("gap_idle_wr", 32'(bank_wr_en), 32'd0);
      end
      if (c == 22) chk("gap_state", 32'(dut.state), 32'(DRAIN));
    end
    valid_in = 1'b0;

    // Input during DRAIN is dropped and flagged.
    valid_in = 1'b1;
    pxl_in   = 32'd99;
    tick();
    valid_in = 1'b0;
    chk("ovf_no_wr", 32'(bank_wr_en), 32'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    drain(101, 12, 1'b0, 1'b0);
    tick();
    tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_idle", 32'(dut.state), 32'(IDLE));

    // Reset after five outputs abandons the frame.
    fill(201, 1'b0);
    drain(201, 5, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outs("mid_rst");
    fill(301, 1'b1);
    drain(301, 12, 1'b1, 1'b0);

    // Bank 1 reports empty mid-read: reads hold, order preserved.
    tick();
    fill(401, 1'b0);
    drain(401, 12, 1'b0, 1'b1);
    tick();
    tick();
    chk("stall_done_busy", 32'(busy), 32'd0);
    chk("flag_sticky", 32'(flag_err), 32'(FLAG_EXP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
